// File: rtl/serial_sum_deser_pkg.sv
// serial_sum_deser_pkg
//   Shared definitions for the serial-sum deserializer slice:
//   - state_t       : deserializer state (IDLE, SHIFT, HOLD)
//   - DEFAULT_WIDTH : default word length in bits
`timescale 1ns/1ps

package serial_sum_deser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // IDLE  : no partial word held
  // SHIFT : 1..WIDTH-1 bits collected
  // HOLD  : full word presented downstream
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sum_deser_bit_counter.sv
// serial_bit_counter
//   Bit index counter for the deserializer. Counts 0..WIDTH-1 and flags the
//   terminal count so the parent knows the current beat completes the word.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : load zero
//   inc         : increment (clear+inc together loads one)
//   count       : current bit index
//   terminal    : count == WIDTH-1
`timescale 1ns/1ps

import serial_sum_deser_pkg::*;

module serial_bit_counter #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     inc,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     terminal
);

  localparam int CW = $clog2(WIDTH);

  // clear+inc means "this beat is bit 0, next index is 1"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear && inc) begin
      count <= CW'(1);
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_sum_deser.sv
// serial_sum_deser
//   Collects the LSB-first sum bits of a bit-serial adder into parallel
//   words with a valid/ready handshake on both sides.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : serial beat handshake
//   in_first            : beat is bit 0 of a new word
//   in_sum              : serial sum bit
//   in_cout             : adder carry-out, sampled with the last bit
//   out_valid/out_ready : word handshake
//   out_data            : assembled word (bit i = i-th beat)
//   out_carry           : carry captured with the last bit
//   frame_err           : one-cycle pulse on a framing violation
`timescale 1ns/1ps

import serial_sum_deser_pkg::*;

module serial_sum_deser #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  input  logic             out_ready,
  output logic             frame_err
);

  state_t                     state;
  logic [$clog2(WIDTH)-1:0]   bit_cnt;
  logic                       bit_last;
  logic                       cnt_clear;
  logic                       cnt_inc;
  logic                       accept;
  logic [WIDTH-1:0]           bit0_word;

  serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .count    (bit_cnt),
    .terminal (bit_last)
  );

  // A presented word blocks new beats unless it is being consumed this
  // same cycle, which lets words stream back-to-back.
  assign in_ready  = (state != HOLD) || out_ready;
  assign accept    = in_valid && in_ready;
  // Bit-0 store also clears the upper bits so no stale data survives.
  assign bit0_word = {{(WIDTH-1){1'b0}}, in_sum};

  // Counter control: any first beat restarts at index 1; the last bit
  // returns the counter to zero so it never passes WIDTH-1.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    if (accept) begin
      if (in_first) begin
        cnt_clear = 1'b1;
        cnt_inc   = 1'b1;
      end else if (state == SHIFT) begin
        if (bit_last) cnt_clear = 1'b1;
        else          cnt_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_first) begin
              out_data <= bit0_word;
              state    <= SHIFT;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (accept) begin
            if (in_first) begin
              // Abort the partial word and restart with this beat.
              frame_err <= 1'b1;
              out_data  <= bit0_word;
            end else begin
              out_data[bit_cnt] <= in_sum;
              if (bit_last) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                out_carry <= in_cout;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            // in_ready is high here, so any valid beat is accepted.
            if (in_valid) begin
              if (in_first) begin
                out_data <= bit0_word;
                state    <= SHIFT;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sum_deser.sv
`timescale 1ns/1ps

module tb_serial_sum_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         in_sum = 1'b0;
  logic         in_cout = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_carry;
  logic         out_ready = 1'b0;
  logic         frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  serial_sum_deser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic s, input logic c);
    in_valid = 1'b1;
    in_first = f;
    in_sum   = s;
    in_cout  = c;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic c);
    for (int i = 0; i < W; i++) beat(i == 0, w[i], (i == W-1) ? c : 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
    if (out_carry !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_carry: got %b expected 0", out_carry); end
    if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tick();
  endtask

  task automatic test_single_word();
    logic b [W];
    b = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < W; i++) begin
      beat(i == 0, b[i], (i == W-1));
      if (i == W-2) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_valid: got %b expected 0", out_valid); end
      end
    end
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'h4D) begin n_fail++; $display("[TB] FAIL single_data: got %h expected 4d", out_data); end
    if (out_carry !== 1'b1) begin n_fail++; $display("[TB] FAIL single_carry: got %b expected 1", out_carry); end
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [2];
    logic [W-1:0] seen [$];
    int ready_drops;
    words = '{8'hA5, 8'h3C};
    ready_drops = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < W; i++) begin
        if (in_ready !== 1'b1) ready_drops++;
        beat(i == 0, words[k][i], 1'b0);
        if (out_valid === 1'b1) seen.push_back(out_data);
      end
    end
    idle();
    n_checks += 2;
    if (ready_drops != 0) begin n_fail++; $display("[TB] FAIL b2b_in_ready_drops: got %0d expected 0", ready_drops); end
    if (seen.size() != 2) begin n_fail++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", seen.size()); end
    else begin
      n_checks += 2;
      if (seen[0] !== 8'hA5) begin n_fail++; $display("[TB] FAIL b2b_word0: got %h expected a5", seen[0]); end
      if (seen[1] !== 8'h3C) begin n_fail++; $display("[TB] FAIL b2b_word1: got %h expected 3c", seen[1]); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send_word(8'hFF, 1'b1);
    out_ready = 1'b0;
    // offer a new word's first beat while stalled; it must not be taken
    in_valid = 1'b1;
    in_first = 1'b1;
    in_sum   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", c, out_valid); end
      if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready); end
      if (out_data !== 8'hFF) begin n_fail++; $display("[TB] FAIL stall_data[%0d]: got %h expected ff", c, out_data); end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_abort();
    logic [W-1:0] w;
    w = 8'h81;
    out_ready = 1'b1;
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) begin
      beat(i == 0, w[i], (i == W-1));
      if (i == 0) begin
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_frame_err: got %b expected 1", frame_err); end
      end else if (i == 1) begin
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_pulse_width: got %b expected 0", frame_err); end
      end
    end
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'h81) begin n_fail++; $display("[TB] FAIL abort_data: got %h expected 81", out_data); end
    if (out_carry !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_carry: got %b expected 1", out_carry); end
    idle();
  endtask

  task automatic test_idle_frame_err();
    out_ready = 1'b1;
    beat(1'b0, 1'b1, 1'b0);
    n_checks += 2;
    if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_frame_err: got %b expected 1", frame_err); end
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_no_valid: got %b expected 0", out_valid); end
    idle();
    n_checks += 2;
    if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_frame_err_clear: got %b expected 0", frame_err); end
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_no_valid_later: got %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w;
    w = 8'hB7;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(i == 0, w[i], 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL areset_data: got %h expected 00", out_data); end
    if (out_carry !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_carry: got %b expected 0", out_carry); end
    if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_frame_err: got %b expected 0", frame_err); end
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_in_ready: got %b expected 1", in_ready); end
    #3 rst_n = 1'b1;
    send_word(8'h5A, 1'b0);
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL post_reset_data: got %h expected 5a", out_data); end
    if (out_carry !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_carry: got %b expected 0", out_carry); end
    idle();
  endtask

  // Reference: a queue of bits collected so far and one presented-word slot.
  task automatic test_random();
    bit           bits [$];
    logic         pend_v;
    logic [W-1:0] pend_d;
    logic         pend_c;
    logic         exp_ready;
    logic         exp_ferr;
    logic         v, f, s, co, r;
    pend_v = 1'b0;
    pend_d = '0;
    pend_c = 1'b0;
    out_ready = 1'b1;
    idle();
    idle();
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      f  = (bits.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 15) == 0);
      s  = 1'($urandom_range(0, 1));
      co = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 3) != 0);
      in_valid  = v;
      in_first  = f;
      in_sum    = s;
      in_cout   = co;
      out_ready = r;
      #1;
      exp_ready = !pend_v || r;
      n_checks++;
      if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, exp_ready); end
      exp_ferr = 1'b0;
      if (pend_v && r) pend_v = 1'b0;
      if (v && exp_ready) begin
        if (f) begin
          if (bits.size() != 0) exp_ferr = 1'b1;
          bits = {};
          bits.push_back(s);
        end else if (bits.size() == 0) begin
          exp_ferr = 1'b1;
        end else begin
          bits.push_back(s);
          if (bits.size() == W) begin
            pend_d = '0;
            for (int i = 0; i < W; i++) pend_d = pend_d + (W'(bits[i]) << i);
            pend_c = co;
            pend_v = 1'b1;
            bits = {};
          end
        end
      end
      @(posedge clk);
      #1;
      n_checks += 2;
      if (out_valid !== pend_v) begin n_fail++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", c, out_valid, pend_v); end
      if (frame_err !== exp_ferr) begin n_fail++; $display("[TB] FAIL rand_frame_err[%0d]: got %b expected %b", c, frame_err, exp_ferr); end
      if (pend_v) begin
        n_checks += 2;
        if (out_data !== pend_d) begin n_fail++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", c, out_data, pend_d); end
        if (out_carry !== pend_c) begin n_fail++; $display("[TB] FAIL rand_carry[%0d]: got %b expected %b", c, out_carry, pend_c); end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_idle_frame_err();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sum_deser.md
SERIAL_SUM_DESER -- requirements
Module: serial_sum_deser

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  serial beat present.
REQ-005 in_first  input  1  beat is bit 0 of a new word; qualified by in_valid.
REQ-006 in_sum  input  1  serial sum bit, LSB first.
REQ-007 in_cout  input  1  carry-out of the serial adder; meaningful only on bit WIDTH-1.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 out_valid  output  1  assembled word available.
REQ-010 out_data  output  WIDTH  assembled word, bit i = i-th accepted beat.
REQ-011 out_carry  output  1  in_cout captured with bit WIDTH-1.
REQ-012 out_ready  input  1  downstream accepts word.
REQ-013 frame_err  output  1  one-cycle pulse on framing violation.

Function
REQ-014 A beat is accepted when in_valid && in_ready at a rising clk edge; a word is consumed when out_valid && out_ready.
REQ-015 States: IDLE (no partial word), SHIFT (1..WIDTH-1 bits held), HOLD (full word presented, out_valid=1).
REQ-016 IDLE: only a beat with in_first=1 is accepted into bit 0 -> SHIFT; in_valid with in_first=0 is accepted, discarded, and pulses frame_err the next cycle.
REQ-017 SHIFT: each accepted beat stores in_sum at index bit_cnt and increments bit_cnt; bit WIDTH-1 accepted -> HOLD, out_carry <= in_cout.
REQ-018 SHIFT: accepted beat with in_first=1 aborts the partial word, pulses frame_err, and restarts at bit 0 with that beat.
REQ-019 out_valid rises the cycle after bit WIDTH-1 is accepted (latency 1 from last beat); out_data/out_carry stable while out_valid && !out_ready.
REQ-020 in_ready = 1 in IDLE and SHIFT; in HOLD in_ready = out_ready (back-to-back words allowed).
REQ-021 HOLD with out_ready=1 and accepted in_first beat: word consumed and new word bit 0 stored in same cycle -> SHIFT, no bubble; HOLD with out_ready=1 and no beat -> IDLE.
REQ-022 HOLD with accepted beat having in_first=0 cannot occur legally: beat discarded, frame_err pulsed, word still consumed.
REQ-023 bit_cnt is clog2(WIDTH) wide and never exceeds WIDTH-1; no wrap-around past HOLD.
REQ-024 Unwritten upper bits of the partial word are cleared on each bit-0 store, so out_data never contains stale bits.

Reset
REQ-025 rst_n low asynchronously forces IDLE, bit_cnt=0, out_valid=0, out_data=0, out_carry=0, frame_err=0.
REQ-026 Reset mid-word or in HOLD discards the partial/presented word with no frame_err.
REQ-027 in_ready=1 in the first cycle after reset release.

Structure
REQ-028 Shared package holds the state enum (IDLE, SHIFT, HOLD) and the default WIDTH constant.
REQ-029 One sub-module, serial_bit_counter (load-zero, increment, terminal-count flag at WIDTH-1), is instantiated once.
REQ-030 All other logic is in a single clocked process plus combinational ready/next-state logic; no negedge logic.

Verification
REQ-031 WIDTH=8, beats 1,0,1,1,0,0,1,0 (first on beat 0), cout=1 on last, out_ready=1 -> out_valid one cycle after last beat, out_data=8'h4D, out_carry=1.
REQ-032 Two words 8'hA5, 8'h3C streamed back-to-back, out_ready=1 -> in_ready never drops, two out_valid pulses, data A5 then 3C.
REQ-033 Word 8'hFF complete, out_ready=0 for 5 cycles -> out_valid held, in_ready=0, out_data stable FF; out_ready=1 -> consumed next edge.
REQ-034 4 bits sent, then beat with in_first=1 -> frame_err pulse, subsequent 8 beats of 8'h81 yield out_data=8'h81.
REQ-035 in_valid=1, in_first=0 in IDLE -> frame_err pulse, no out_valid; rst_n low after 5 bits -> all outputs 0 asynchronously, IDLE on release.
